// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keycode receiver.
//   frame_state_t  - states of the PS/2 frame FSM (IDLE, DATA, PARITY, STOP)
//   BREAK_PREFIX   - scan-code byte announcing a key release
//   EXT_PREFIX     - scan-code byte announcing an extended (E0) key
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line front end and frame receiver.
// Synchronizes ps2_clk/ps2_data, deglitches ps2_clk, turns each falling edge
// of the filtered clock into a one-cycle sample strobe and assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   ps2_clk/ps2_data raw keyboard lines (asynchronous to clk)
//   rx_byte[7:0]     received data byte, stable while the FSM is not in DATA
//   byte_ok          one-cycle pulse: good frame, rx_byte valid
//   byte_err         one-cycle pulse: parity error, stop-bit error or timeout
//   frame_state      current FSM state (debug)
// Handshake: byte_ok/byte_err are single-cycle, no back-pressure; the
// consumer must take rx_byte in the cycle byte_ok is high.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err,
    output logic [1:0] frame_state
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic          timeout;

    frame_state_t  state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          parity, parity_nxt;
    logic          ok_nxt, err_nxt;
    logic [15:0]   to_cnt;

    // Two-flop synchronizers; reset to the bus idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock follows only after FILTER_LEN consecutive samples
    // that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign strobe  = clk_filt_d & ~clk_filt;
    assign timeout = (state != IDLE) && (to_cnt == 16'(TIMEOUT_CYCLES));

    // Idle-time counter: runs only mid-frame, cleared by every strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == IDLE || strobe) begin
            to_cnt <= '0;
        end else if (to_cnt != 16'hFFFF) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            byte_ok  <= 1'b0;
            byte_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            parity   <= parity_nxt;
            byte_ok  <= ok_nxt;
            byte_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        parity_nxt  = parity;
        ok_nxt      = 1'b0;
        err_nxt     = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else if (strobe) begin
            case (state)
                IDLE: begin
                    // A high start bit is noise; stay idle.
                    if (!dat_s2) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    parity_nxt = dat_s2;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    // Odd parity over data+parity and a high stop bit.
                    if ((^{shift, parity}) && dat_s2) begin
                        ok_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rx_byte     = shift;
    assign frame_state = state;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard receiver presenting the held key.
// Decodes E0 / F0 prefixes from good bytes and tracks the single key
// currently held.
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   ps2_clk/ps2_data raw keyboard lines
//   keycode[7:0]     make code of the held key, 8'h00 when none
//   key_ext          held key came from an E0-prefixed sequence
//   key_valid        one-cycle pulse when keycode or key_ext changes
//   frame_err        one-cycle pulse on parity/stop error or timeout
//   frame_state      frame FSM state (debug)
// Handshake: key_valid/frame_err are single-cycle strobes, no ready.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err,
    output logic [1:0] frame_state
);

    logic [7:0] rx_byte;
    logic       byte_ok, byte_err;
    logic       ext_pending, brk_pending;
    logic       ep_nxt, bp_nxt;
    logic [7:0] code_nxt;
    logic       ext_nxt, valid_nxt;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_ok    (byte_ok),
        .byte_err   (byte_err),
        .frame_state(frame_state)
    );

    // Errored frames leave the pending flags untouched, so a prefix
    // survives a corrupted following frame.
    always_comb begin
        code_nxt = keycode;
        ext_nxt  = key_ext;
        ep_nxt   = ext_pending;
        bp_nxt   = brk_pending;
        if (byte_ok) begin
            if (rx_byte == EXT_PREFIX) begin
                ep_nxt = 1'b1;
            end else if (rx_byte == BREAK_PREFIX) begin
                bp_nxt = 1'b1;
            end else begin
                ep_nxt = 1'b0;
                bp_nxt = 1'b0;
                if (!brk_pending) begin
                    code_nxt = rx_byte;
                    ext_nxt  = ext_pending;
                end else if (rx_byte == keycode && ext_pending == key_ext) begin
                    // Release only of the key actually held.
                    code_nxt = 8'h00;
                    ext_nxt  = 1'b0;
                end
            end
        end
        // Auto-repeat and foreign releases produce no pulse.
        valid_nxt = (code_nxt != keycode) || (ext_nxt != key_ext);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keycode     <= 8'h00;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else begin
            keycode     <= code_nxt;
            key_ext     <= ext_nxt;
            key_valid   <= valid_nxt;
            ext_pending <= ep_nxt;
            brk_pending <= bp_nxt;
        end
    end

    assign frame_err = byte_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: randomized + directed bench for ps2_keycode_rx with a
// keyboard-level reference model and an event scoreboard.
module tb_ps2_keycode_rx;

    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int HALF = 20;
    localparam int W    = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;
    logic [1:0] frame_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stop_fall_cyc = 0;

    // Expected events: {frame_err, key_ext, keycode}; lat_q marks which
    // events are tied to a stop bit and get a latency window check.
    logic [W-1:0] exp_q[$];
    bit           lat_q[$];

    // Reference model: what the keyboard has told us so far.
    logic [7:0] m_code;
    logic       m_ext, m_ep, m_bp;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .key_ext    (key_ext),
        .key_valid  (key_valid),
        .frame_err  (frame_err),
        .frame_state(frame_state)
    );

    // ---------------- model ----------------
    task automatic model_reset();
        m_code = 8'h00;
        m_ext  = 1'b0;
        m_ep   = 1'b0;
        m_bp   = 1'b0;
        exp_q.delete();
        lat_q.delete();
    endtask

    task automatic push_err(input bit lat);
        exp_q.push_back({1'b1, m_ext, m_code});
        lat_q.push_back(lat);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] old_code;
        logic       old_ext;
        old_code = m_code;
        old_ext  = m_ext;
        if (b == 8'hE0) m_ep = 1'b1;
        else if (b == 8'hF0) m_bp = 1'b1;
        else begin
            if (!m_bp) begin
                m_code = b;
                m_ext  = m_ep;
            end else if (b == m_code && m_ep == m_ext) begin
                m_code = 8'h00;
                m_ext  = 1'b0;
            end
            m_ep = 1'b0;
            m_bp = 1'b0;
        end
        if (m_code != old_code || m_ext != old_ext) begin
            exp_q.push_back({1'b0, m_ext, m_code});
            lat_q.push_back(1'b1);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input logic b, input bit is_stop);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) stop_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        if (bad_par || bad_stop) push_err(1'b1);
        else model_byte(b);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(~bad_stop, 1'b1);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic check_outputs(input string name);
        total++;
        if (keycode !== m_code || key_ext !== m_ext) begin
            bad++;
            $display("FAIL %s: got code=%h ext=%b, want code=%h ext=%b",
                     name, keycode, key_ext, m_code, m_ext);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({keycode, key_ext, key_valid, frame_err} !== 11'd0) begin
            bad++;
            $display("FAIL %s: got code=%h ext=%b valid=%b err=%b, want all 0",
                     name, keycode, key_ext, key_valid, frame_err);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1 && (key_valid === 1'b1 || frame_err === 1'b1)) begin
            logic [W-1:0] exp;
            bit           lat;
            int           d;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got err=%b ext=%b code=%h, want no event",
                         frame_err, key_ext, keycode);
            end else begin
                exp = exp_q.pop_front();
                lat = lat_q.pop_front();
                if ({frame_err, key_ext, keycode} !== exp) begin
                    bad++;
                    $display("FAIL event: got err=%b ext=%b code=%h, want err=%b ext=%b code=%h",
                             frame_err, key_ext, keycode, exp[9], exp[8], exp[7:0]);
                end
                if (lat) begin
                    d = cyc - stop_fall_cyc;
                    total++;
                    if (d < FL + 1 || d > FL + 8) begin
                        bad++;
                        $display("FAIL latency: got %0d cycles after stop fall, want %0d..%0d",
                                 d, FL + 1, FL + 8);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] codes[5];
        logic [7:0] b;
        int         r;
        codes[0] = 8'h1C; codes[1] = 8'h1D; codes[2] = 8'h23;
        codes[3] = 8'h75; codes[4] = 8'h6B;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Make, break, foreign break.
        send_frame(8'h1D, 0, 0);
        check_outputs("make_1d");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        check_outputs("break_1d");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        check_outputs("foreign_break");

        // Extended make and break.
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        check_outputs("ext_make");
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check_outputs("ext_break");

        // Parity error, then prefix surviving a bad frame.
        send_frame(8'h1D, 0, 0);
        send_frame(8'h1D, 1, 0);
        check_outputs("parity_err");
        send_frame(8'hE0, 0, 0);
        send_frame(8'h33, 0, 1);
        send_frame(8'h6B, 0, 0);
        check_outputs("prefix_kept");

        // Timeout after five bits.
        push_err(1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[0] ^ 1'b1, 1'b0);
        ps2_data = 1'b1;
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h23, 0, 0);
        check_outputs("after_timeout");

        // Reset in the middle of a frame.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("mid_frame_reset");
        reset_n  = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1D, 0, 0);
        send_frame(8'h1D, 0, 0);
        check_outputs("post_reset_repeat");

        // Random keyboard traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 11);
            b = codes[$urandom_range(0, 4)];
            case (r)
                0, 1:    send_frame(8'hE0, 0, 0);
                2, 3, 4: send_frame(8'hF0, 0, 0);
                5:       send_frame(b, 1, 0);
                6:       send_frame(b, 0, 1);
                default: send_frame(b, 0, 0);
            endcase
        end
        check_outputs("random_final");

        repeat (50) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d unconsumed, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #5ms;
        bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: number of consecutive equal synchronized samples of ps2_clk required before the filtered level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: idle clk cycles allowed mid-frame before the frame is abandoned (1 ms at 50 MHz).
REQ-003 clk  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 keycode  output  8  make code of the key currently held; 8'h00 when no key is held; drives the keycode PIO in_port.
REQ-008 key_ext  output  1  1 when keycode came from an E0-prefixed sequence.
REQ-009 key_valid  output  1  one-cycle pulse on each update of keycode or key_ext.
REQ-010 frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-011 ps2_clk and ps2_data shall each pass through a 2-FF synchronizer.
REQ-012 Filtered ps2_clk shall change level only after FILTER_LEN consecutive equal synchronized samples.
REQ-013 A falling edge of filtered ps2_clk shall assert a one-cycle sample strobe, and the synchronized ps2_data shall be sampled on that strobe.
REQ-014 The frame FSM shall use the states IDLE, DATA, PARITY and STOP.
- IDLE -> DATA on a strobe with data=0; a strobe with data=1 in IDLE is ignored.
- DATA shifts in 8 bits, LSB first; a 3-bit counter moves to PARITY after bit 7.
- PARITY -> STOP, latching the parity bit.
- STOP -> IDLE on the next strobe.
REQ-015 A frame is good when data bits plus parity bit contain an odd number of 1s and the stop bit = 1; any other frame pulses frame_err and is discarded.
REQ-016 In any state other than IDLE, a 16-bit counter shall count cycles since the last strobe.
- When it reaches TIMEOUT_CYCLES the FSM returns to IDLE, the partial frame is discarded and frame_err pulses.
- A strobe clears the counter.
REQ-017 The decoder shall process good bytes as follows.
- 8'hE0 sets ext_pending.
- 8'hF0 sets brk_pending.
- Any other byte is a code, after which both pending flags clear.
REQ-018 A make code (brk_pending=0) shall set keycode to the code and key_ext to ext_pending.
REQ-019 A break code (brk_pending=1) shall clear keycode to 8'h00 and key_ext to 0 only when the code and ext_pending match the current keycode and key_ext; otherwise outputs are unchanged.
REQ-020 key_valid shall pulse only when keycode or key_ext actually changes value.
REQ-021 Latency: keycode, key_ext and key_valid shall update on the 2nd clk edge after the strobe for the stop bit.
REQ-022 frame_err shall pulse on the 1st clk edge after the stop-bit strobe, or on the edge at which the timeout is detected.
REQ-023 A prefix byte followed by an errored frame shall keep its pending flag; the flags clear only on a good code byte or reset.
REQ-024 Auto-repeat make codes with unchanged value shall not pulse key_valid.

Reset
REQ-025 While reset_n=0 the following shall hold.
- keycode=8'h00, key_ext=0, key_valid=0, frame_err=0.
- FSM in IDLE, pending flags clear, counters clear.
- Synchronizers and filter at 1 (the bus idle level).
REQ-026 Reset asserted mid-frame shall discard the partial frame; the next frame after release shall decode normally.

Structure
REQ-027 A package ps2_pkg shall hold the FSM state enum, BREAK_PREFIX=8'hF0 and EXT_PREFIX=8'hE0.
REQ-028 Synchronizer, filter, edge detect, frame FSM and timeout shall live in sub-module ps2_frame_rx, which outputs byte[7:0], byte_ok and byte_err.
REQ-029 ps2_keycode_rx shall instantiate ps2_frame_rx and hold the prefix decoder and output registers.

Verification
REQ-030 Frame 0x1D, parity=1, stop=1 -> keycode=8'h1D, key_ext=0, one key_valid pulse two cycles after the stop-bit strobe.
REQ-031 Bytes F0,1D after REQ-030 -> keycode=8'h00, one key_valid pulse; then F0,1C -> no change, no pulse.
REQ-032 Bytes E0,75 -> keycode=8'h75, key_ext=1; then E0,F0,75 -> keycode=8'h00, key_ext=0.
REQ-033 Frame 0x1D with parity=0 -> frame_err pulses once, keycode unchanged, no key_valid.
REQ-034 Five bits, then idle for TIMEOUT_CYCLES+10, then good frame 0x23 -> exactly one frame_err pulse, then keycode=8'h23.
REQ-035 reset_n pulsed low after 4 bits of 0x1D, then full frame 0x1D -> all outputs 0 during reset, then keycode=8'h1D; also repeat 0x1D twice -> one key_valid total.
